// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide unit: FSM state encoding,
// latency constants and a magnitude helper used by the divider.
// ---------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL      = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DONE     = 3'd4
  } md_state_e;

  localparam int MUL_LAT_DEFAULT = 3;
  localparam int DIV_ITERS       = 32;
  localparam int DIV_LAT         = 34;
  localparam int DIV_CNT_W       = 6;

  // Magnitude of a 32-bit operand; only negated when the operation is signed.
  // 32'h80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/md_divider.sv
// ---------------------------------------------------------------------------
// md_divider
// 32-bit restoring divider: captures operand magnitudes on load, runs one
// quotient bit per iter_en cycle, then applies signs while fix_en is high.
// Ports:
//   clk, reset         clock, async active-high reset
//   load               capture src1/src2/is_signed and restart
//   iter_en            perform one restoring step
//   fix_en             sign-correct and register the result
//   clear              abandon the current operation
//   is_signed, src1/2  operands (sampled on load)
//   last_iter          the current step is the final (32nd) one
//   fix_valid          result holds the sign-corrected answer
//   result             {remainder, quotient}
// ---------------------------------------------------------------------------
module md_divider
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        iter_en,
  input  logic        fix_en,
  input  logic        clear,
  input  logic        is_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        last_iter,
  output logic        fix_valid,
  output logic [63:0] result
);

  logic [31:0]          quo_r, rem_r, dvs_r, dvd_raw_r;
  logic                 neg_q_r, neg_r_r, dz_r, fix_valid_r;
  logic [DIV_CNT_W-1:0] cnt_r;
  logic [63:0]          result_r;

  logic [32:0] rem_sh_s, diff_s;
  logic [31:0] quo_nx_s, rem_nx_s, q_fix_s, r_fix_s;

  assign last_iter = (cnt_r == DIV_CNT_W'(DIV_ITERS - 1));
  assign fix_valid = fix_valid_r;
  assign result    = result_r;

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
  always_comb begin
    rem_sh_s = {rem_r, quo_r[31]};
    diff_s   = rem_sh_s - {1'b0, dvs_r};
    if (!diff_s[32]) begin
      rem_nx_s = diff_s[31:0];
      quo_nx_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_nx_s = rem_sh_s[31:0];
      quo_nx_s = {quo_r[30:0], 1'b0};
    end
  end

  // Sign correction; divide-by-zero returns all-ones quotient and the raw dividend.
  always_comb begin
    if (dz_r) begin
      q_fix_s = 32'hFFFF_FFFF;
      r_fix_s = dvd_raw_r;
    end else begin
      q_fix_s = neg_q_r ? (32'd0 - quo_r) : quo_r;
      r_fix_s = neg_r_r ? (32'd0 - rem_r) : rem_r;
    end
  end

  // Divider datapath registers and iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_r       <= 32'd0;
      rem_r       <= 32'd0;
      dvs_r       <= 32'd0;
      dvd_raw_r   <= 32'd0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dz_r        <= 1'b0;
      cnt_r       <= '0;
      fix_valid_r <= 1'b0;
      result_r    <= 64'd0;
    end else if (load) begin
      quo_r       <= mag32(src1, is_signed);
      rem_r       <= 32'd0;
      dvs_r       <= mag32(src2, is_signed);
      dvd_raw_r   <= src1;
      neg_q_r     <= is_signed & (src1[31] ^ src2[31]);
      neg_r_r     <= is_signed & src1[31];
      dz_r        <= (src2 == 32'd0);
      cnt_r       <= '0;
      fix_valid_r <= 1'b0;
    end else if (clear) begin
      cnt_r       <= '0;
      fix_valid_r <= 1'b0;
    end else if (iter_en) begin
      quo_r <= quo_nx_s;
      rem_r <= rem_nx_s;
      cnt_r <= last_iter ? '0 : cnt_r + DIV_CNT_W'(1);
    end else if (fix_en) begin
      // fix_valid toggles so the FSM sees exactly one ready cycle after the fix cycle.
      result_r    <= {r_fix_s, q_fix_s};
      fix_valid_r <= ~fix_valid_r;
    end else begin
      fix_valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// HI/LO multiply/divide unit. Multiply completes MUL_LAT cycles after
// accept, divide completes 34 cycles after accept.
// Ports:
//   clk, reset         clock, async active-high reset
//   mult_en, div_en    one-cycle requests (multiply wins on collision)
//   is_signed          signed operation when 1
//   src1, src2         rs / rt operands, latched on accept
//   cancel             flush the in-flight operation
//   busy               operation in flight (through the complete cycle)
//   MD_complete        one-cycle result-valid pulse
//   MD_result          {HI, LO}
// ---------------------------------------------------------------------------
module mul_div_unit
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_en,
  input  logic        div_en,
  input  logic        is_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        cancel,
  output logic        busy,
  output logic        MD_complete,
  output logic [63:0] MD_result
);

  md_state_e   state_r;
  logic [31:0] a_r, b_r;
  logic        sgn_r;
  logic [7:0]  mul_cnt_r;

  logic [63:0] ext_a_s, ext_b_s, prod_s;
  logic        div_load_s, div_last_s, div_fix_valid_s;
  logic [63:0] div_result_s;

  // Full 64-bit product from sign- or zero-extended latched operands.
  always_comb begin
    if (sgn_r) begin
      ext_a_s = {{32{a_r[31]}}, a_r};
      ext_b_s = {{32{b_r[31]}}, b_r};
    end else begin
      ext_a_s = {32'd0, a_r};
      ext_b_s = {32'd0, b_r};
    end
    prod_s = ext_a_s * ext_b_s;
  end

  assign div_load_s = (state_r == IDLE) && div_en && !mult_en && !cancel;

  md_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load_s),
    .iter_en   (state_r == DIV_ITER),
    .fix_en    (state_r == DIV_FIX),
    .clear     (cancel),
    .is_signed (is_signed),
    .src1      (src1),
    .src2      (src2),
    .last_iter (div_last_s),
    .fix_valid (div_fix_valid_s),
    .result    (div_result_s)
  );

  // Control FSM with registered busy/complete/result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      sgn_r       <= 1'b0;
      mul_cnt_r   <= 8'd0;
      busy        <= 1'b0;
      MD_complete <= 1'b0;
      MD_result   <= 64'd0;
    end else begin
      MD_complete <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cancel) begin
            state_r <= IDLE;
          end else if (mult_en) begin
            a_r       <= src1;
            b_r       <= src2;
            sgn_r     <= is_signed;
            mul_cnt_r <= 8'd0;
            busy      <= 1'b1;
            state_r   <= MUL;
          end else if (div_en) begin
            busy    <= 1'b1;
            state_r <= DIV_ITER;
          end
        end
        MUL: begin
          if (cancel) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (mul_cnt_r == 8'(MUL_LAT - 1)) begin
            MD_result   <= prod_s;
            MD_complete <= 1'b1;
            state_r     <= DONE;
          end else begin
            mul_cnt_r <= mul_cnt_r + 8'd1;
          end
        end
        DIV_ITER: begin
          if (cancel) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (div_last_s) begin
            state_r <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          if (cancel) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (div_fix_valid_s) begin
            MD_result   <= div_result_s;
            MD_complete <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Self-checking bench: a cycle-level behavioural model (latency countdown
// plus plain-arithmetic results) is compared against the DUT on every
// falling edge; directed cases pin literal results and latencies.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int ML = 3;
  localparam int DL = md_pkg::DIV_LAT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mult_en = 1'b0, div_en = 1'b0, is_signed = 1'b0, cancel = 1'b0;
  logic [31:0] src1 = 32'd0, src2 = 32'd0;
  logic        busy, MD_complete;
  logic [63:0] MD_result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state: 0 idle, 1 in flight, 2 done cycle
  int          m_phase = 0;
  int          m_left = 0;
  logic [63:0] m_res = 64'd0;
  logic        exp_busy = 1'b0, exp_complete = 1'b0;
  logic [63:0] exp_result = 64'd0;

  mul_div_unit #(.MUL_LAT(ML)) dut (
    .clk         (clk),
    .reset       (reset),
    .mult_en     (mult_en),
    .div_en      (div_en),
    .is_signed   (is_signed),
    .src1        (src1),
    .src2        (src2),
    .cancel      (cancel),
    .busy        (busy),
    .MD_complete (MD_complete),
    .MD_result   (MD_result)
  );

  // clock generation
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    if (sg) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end else begin
      u = {32'd0, a} * {32'd0, b};
      return u;
    end
  endfunction

  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = int'(a);
      sb = int'(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
    end else begin
      return {a % b, a / b};
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: accept rules, latency countdown, cancel and reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_left <= 0; m_res <= 64'd0;
      exp_busy <= 1'b0; exp_complete <= 1'b0; exp_result <= 64'd0;
    end else begin
      exp_complete <= 1'b0;
      case (m_phase)
        0: if (!cancel && (mult_en || div_en)) begin
          m_phase  <= 1;
          exp_busy <= 1'b1;
          if (mult_en) begin
            m_left <= ML;
            m_res  <= ref_mul(is_signed, src1, src2);
          end else begin
            m_left <= DL;
            m_res  <= ref_div(is_signed, src1, src2);
          end
        end
        1: if (cancel) begin
          m_phase <= 0; exp_busy <= 1'b0;
        end else if (m_left == 1) begin
          m_phase <= 2; exp_complete <= 1'b1; exp_result <= m_res;
        end else begin
          m_left <= m_left - 1;
        end
        default: begin
          m_phase <= 0; exp_busy <= 1'b0;
        end
      endcase
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("complete", {63'd0, MD_complete}, {63'd0, exp_complete});
      chk("result", MD_result, exp_result);
    end
  end

  task automatic issue(input logic m, input logic d, input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mult_en = m; div_en = d; is_signed = sg; src1 = a; src2 = b;
    @(negedge clk);
    mult_en = 1'b0; div_en = 1'b0;
    src1 = $urandom; src2 = $urandom; is_signed = ~sg;
  endtask

  task automatic wait_done(input string name, input int max, output int cyc);
    cyc = 0;
    while (!MD_complete && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (!MD_complete) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_complete required=complete within %0d", name, max);
    end
  endtask

  task automatic run_lit(input string name, input logic m, input logic d, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [63:0] exp_res);
    int cyc;
    issue(m, d, sg, a, b);
    wait_done(name, 60, cyc);
    chk({name, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({name, "_res"}, MD_result, exp_res);
  endtask

  task automatic no_complete(input string name, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (MD_complete) cnt++;
    end
    chk(name, 64'(cnt), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_result", MD_result, 64'd0);
    reset = 1'b0;

    run_lit("smul_m3x5", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 3, 64'hFFFF_FFFF_FFFF_FFF1);
    run_lit("umul_max", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 64'hFFFF_FFFE_0000_0001);
    run_lit("sdiv_m7d2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_lit("udiv_100d7", 1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14});
    run_lit("div_zero", 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'd0, 34, {32'h1234_5678, 32'hFFFF_FFFF});
    run_lit("sdiv_zero_neg", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 34, {32'h8000_0000, 32'hFFFF_FFFF});
    run_lit("sdiv_ovf", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'd0, 32'h8000_0000});

    // divide with a second request at cycle 5 and a cancel at cycle 10
    issue(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    div_en = 1'b1; src1 = 32'd5; src2 = 32'd1;
    @(negedge clk);
    div_en = 1'b0;
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    chk("cancel_keep_result", MD_result, {32'd0, 32'h8000_0000});
    no_complete("cancel_no_complete", 40);

    // cancel coincident with a request in IDLE
    @(negedge clk);
    mult_en = 1'b1; cancel = 1'b1; src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    mult_en = 1'b0; cancel = 1'b0;
    chk("cancel_req_busy", {63'd0, busy}, 64'd0);
    no_complete("cancel_req_no_complete", 6);

    run_lit("mul_priority", 1'b1, 1'b1, 1'b0, 32'd7, 32'd6, 3, 64'd42);

    // asynchronous reset mid-divide
    issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FF00, 32'd7);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_complete", {63'd0, MD_complete}, 64'd0);
    chk("async_rst_result", MD_result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    no_complete("rst_no_complete", 40);
    run_lit("rst_mul_2x3", 1'b1, 1'b0, 1'b0, 32'd2, 32'd3, ML, 64'd6);

    // randomized traffic, including requests while busy and stray cancels
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      mult_en   = ($urandom_range(0, 9) == 0);
      div_en    = ($urandom_range(0, 5) == 0);
      cancel    = ($urandom_range(0, 79) == 0);
      is_signed = 1'($urandom_range(0, 1));
      src1      = pick();
      src2      = pick();
    end
    @(negedge clk);
    mult_en = 1'b0; div_en = 1'b0; cancel = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: cycles from accept to complete for multiply (fixed, at least 2).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port mult_en, input, 1: one-cycle multiply request.
REQ-005 SHALL have port div_en, input, 1: one-cycle divide request.
REQ-006 SHALL have port is_signed, input, 1: signed operation when 1, unsigned when 0; sampled with the request.
REQ-007 SHALL have port src1, input, 32: multiplicand / dividend (rs).
REQ-008 SHALL have port src2, input, 32: multiplier / divisor (rt).
REQ-009 SHALL have port cancel, input, 1: exception flush; aborts the in-flight operation.
REQ-010 SHALL have port busy, output, 1: operation in flight; decode stalls HI/LO readers on it.
REQ-011 SHALL have port MD_complete, output, 1: one-cycle pulse, result valid.
REQ-012 SHALL have port MD_result, output, 64: {HI, LO}.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV_ITER, DIV_FIX, DONE.
REQ-014 SHALL accept a request only in IDLE; mult_en or div_en in any other state is ignored.
REQ-015 SHALL give mult_en priority when mult_en and div_en are both high in the same cycle; the divide is dropped.
REQ-016 SHALL latch src1, src2 and is_signed on accept; later input changes have no effect on the operation.
REQ-017 SHALL keep busy high from the cycle after accept through the cycle MD_complete is high.
REQ-018 Multiply: SHALL pulse MD_complete exactly MUL_LAT cycles after the accept edge.
REQ-019 Multiply: SHALL set MD_result to the full 64-bit product (HI = upper 32 bits, LO = lower 32 bits), signed or unsigned per is_signed.
REQ-020 Divide: SHALL register absolute values when signed, then perform 32 restoring-division iterations in DIV_ITER using a 6-bit counter (0..31).
REQ-021 Divide: DIV_FIX SHALL apply signs: quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-022 Divide: SHALL pulse MD_complete exactly 34 cycles after the accept edge.
REQ-023 Divide: SHALL set HI = remainder and LO = quotient.
REQ-024 Divide by zero: SHALL produce LO = 32'hFFFFFFFF and HI = src1, with normal latency and no exception.
REQ-025 Signed 32'h80000000 / 32'hFFFFFFFF: SHALL produce LO = 32'h80000000 and HI = 0.
REQ-026 SHALL hold MD_result stable between completes, and SHALL update it only in the MD_complete cycle.
REQ-027 cancel in any non-IDLE state: SHALL return to IDLE next cycle, with no MD_complete and MD_result unchanged.
REQ-028 cancel coincident with a request in IDLE: the request SHALL NOT be accepted.
REQ-029 DONE SHALL return to IDLE the following cycle; a new request SHALL be accepted in the cycle after MD_complete.

Reset
REQ-030 On reset assertion, SHALL immediately force state IDLE, busy 0, MD_complete 0, MD_result 0 and iteration counter 0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard the operation, and SHALL NOT produce MD_complete after release.

Structure
REQ-032 A shared package md_pkg SHALL hold the FSM state encoding, MUL_LAT default, DIV_ITERS = 32 and DIV_LAT = 34.
REQ-033 The divide datapath (abs, iteration, sign fix) SHALL be one sub-module, md_divider; the multiply and FSM stay in the top level.

Verification
REQ-034 Signed mult src1 = 32'hFFFFFFFD (-3), src2 = 5 -> MD_complete at cycle 3; MD_result = 64'hFFFFFFFF_FFFFFFF1.
REQ-035 Unsigned mult src1 = src2 = 32'hFFFFFFFF -> MD_result = 64'hFFFFFFFE_00000001.
REQ-036 Signed div -7/2 -> MD_complete at cycle 34; HI = 32'hFFFFFFFF, LO = 32'hFFFFFFFD. Unsigned 100/7 -> HI = 2, LO = 14.
REQ-037 Divide by zero src1 = 32'h12345678 -> HI = 32'h12345678, LO = 32'hFFFFFFFF. Signed 32'h80000000 / -1 -> LO = 32'h80000000, HI = 0.
REQ-038 Divide started, cancel at cycle 10 -> busy low at cycle 11, no MD_complete, prior MD_result retained. Second div_en at cycle 5 of a divide -> ignored.
REQ-039 Reset asserted asynchronously mid-divide -> outputs 0 without a clock edge; after release, mult_en 2*3 -> MD_result = 6 at MUL_LAT.
